mem_port_arbiter: RTL and testbench

//  Shares one single-ported Avalon-MM memory agent between the core's instruction-fetch host
//  (read-only) and data host (read/write). Two-host arbiter plus sequencing FSM: data has

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-host arbiter sharing one single-ported Avalon-MM memory between instruction fetch (read-only)
// and data (read/write). Data wins arbitration unless fetch has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // fetch host (read-only)
  input  logic [31:0] ibus_address_i,
  input  logic        ibus_read_i,
  output logic [31:0] ibus_agent_to_host_o,
  output logic        ibus_waitrequest_o,
  output logic        ibus_readdatavalid_o,
  // data host
  input  logic [31:0] dbus_address_i,
  input  logic        dbus_read_i,
  input  logic        dbus_write_i,
  input  logic [3:0]  dbus_byteenable_i,
  input  logic [31:0] dbus_host_to_agent_i,
  output logic [31:0] dbus_agent_to_host_o,
  output logic        dbus_waitrequest_o,
  output logic        dbus_readdatavalid_o,
  // downstream memory
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_byteenable_o,
  output logic [31:0] mem_host_to_agent_o,
  input  logic [31:0] mem_agent_to_host_i,
  input  logic        mem_waitrequest_i,
  input  logic        mem_readdatavalid_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntD    = 2'd1;
  localparam logic [1:0] GntI    = 2'd2;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] ibus_rdata_q, ibus_rdata_d;
  logic [31:0] dbus_rdata_q, dbus_rdata_d;

  logic dreq, ireq;
  logic cmd_d, cmd_i, resp_rdv;

  assign dreq     = dbus_read_i | dbus_write_i;
  assign ireq     = ibus_read_i;
  assign cmd_d    = (state_q == StCmd) && (grant_q == GntD);
  assign cmd_i    = (state_q == StCmd) && (grant_q == GntI);
  // Gated by reset so a response landing in the reset cycle never reaches a host.
  assign resp_rdv = (state_q == StResp) && mem_readdatavalid_i && !reset;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    streak_d     = streak_q;
    ibus_rdata_d = ibus_rdata_q;
    dbus_rdata_d = dbus_rdata_q;
    case (state_q)
      StIdle: begin
        grant_d = GntNone;
        if (dreq && !(ireq && (streak_q == Limit))) begin
          grant_d = GntD;
          state_d = StCmd;
          if (!ireq) begin
            streak_d = 4'd0;
          end else if (streak_q < Limit) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (ireq) begin
          grant_d  = GntI;
          state_d  = StCmd;
          streak_d = 4'd0;
        end else begin
          streak_d = 4'd0;
        end
      end
      StCmd: begin
        if (!mem_waitrequest_i) begin
          if (mem_read_o) begin
            state_d = StResp;
          end else begin
            state_d = StIdle;
            grant_d = GntNone;
          end
        end
      end
      StResp: begin
        if (mem_readdatavalid_i) begin
          state_d = StIdle;
          grant_d = GntNone;
          if (grant_q == GntI) begin
            ibus_rdata_d = mem_agent_to_host_i;
          end else if (grant_q == GntD) begin
            dbus_rdata_d = mem_agent_to_host_i;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = GntNone;
      end
    endcase
  end

  always_comb begin
    mem_address_o       = 32'd0;
    mem_read_o          = 1'b0;
    mem_write_o         = 1'b0;
    mem_byteenable_o    = 4'd0;
    mem_host_to_agent_o = 32'd0;
    if (cmd_d) begin
      mem_address_o       = dbus_address_i;
      // Simultaneous read and write from the data host is treated as a write.
      mem_read_o          = dbus_read_i & ~dbus_write_i;
      mem_write_o         = dbus_write_i;
      mem_byteenable_o    = dbus_byteenable_i;
      mem_host_to_agent_o = dbus_host_to_agent_i;
    end else if (cmd_i) begin
      mem_address_o    = ibus_address_i;
      mem_read_o       = 1'b1;
      mem_byteenable_o = 4'b1111;
    end
  end

  always_comb begin
    ibus_waitrequest_o   = cmd_i ? mem_waitrequest_i : 1'b1;
    dbus_waitrequest_o   = cmd_d ? mem_waitrequest_i : 1'b1;
    ibus_readdatavalid_o = resp_rdv && (grant_q == GntI);
    dbus_readdatavalid_o = resp_rdv && (grant_q == GntD);
    ibus_agent_to_host_o = ibus_readdatavalid_o ? mem_agent_to_host_i : ibus_rdata_q;
    dbus_agent_to_host_o = dbus_readdatavalid_o ? mem_agent_to_host_i : dbus_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= GntNone;
      streak_q     <= 4'd0;
      ibus_rdata_q <= 32'd0;
      dbus_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      streak_q     <= streak_d;
      ibus_rdata_q <= ibus_rdata_d;
      dbus_rdata_q <= dbus_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration priority, starvation limit, wait states,
// reset abandonment and simultaneous read/write handling.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_agent_to_host;
  logic        ibus_waitrequest;
  logic        ibus_readdatavalid;
  logic [31:0] dbus_address;
  logic        dbus_read;
  logic        dbus_write;
  logic [3:0]  dbus_byteenable;
  logic [31:0] dbus_host_to_agent;
  logic [31:0] dbus_agent_to_host;
  logic        dbus_waitrequest;
  logic        dbus_readdatavalid;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_host_to_agent;
  logic [31:0] mem_agent_to_host;
  logic        mem_waitrequest;
  logic        mem_readdatavalid;

  int tests_run;
  int tests_failed;

  mem_port_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .ibus_address_i       (ibus_address),
    .ibus_read_i          (ibus_read),
    .ibus_agent_to_host_o (ibus_agent_to_host),
    .ibus_waitrequest_o   (ibus_waitrequest),
    .ibus_readdatavalid_o (ibus_readdatavalid),
    .dbus_address_i       (dbus_address),
    .dbus_read_i          (dbus_read),
    .dbus_write_i         (dbus_write),
    .dbus_byteenable_i    (dbus_byteenable),
    .dbus_host_to_agent_i (dbus_host_to_agent),
    .dbus_agent_to_host_o (dbus_agent_to_host),
    .dbus_waitrequest_o   (dbus_waitrequest),
    .dbus_readdatavalid_o (dbus_readdatavalid),
    .mem_address_o        (mem_address),
    .mem_read_o           (mem_read),
    .mem_write_o          (mem_write),
    .mem_byteenable_o     (mem_byteenable),
    .mem_host_to_agent_o  (mem_host_to_agent),
    .mem_agent_to_host_i  (mem_agent_to_host),
    .mem_waitrequest_i    (mem_waitrequest),
    .mem_readdatavalid_i  (mem_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    reset              = 1'b1;
    ibus_address       = 32'd0;
    ibus_read          = 1'b0;
    dbus_address       = 32'd0;
    dbus_read          = 1'b0;
    dbus_write         = 1'b0;
    dbus_byteenable    = 4'd0;
    dbus_host_to_agent = 32'd0;
    mem_agent_to_host  = 32'd0;
    mem_waitrequest    = 1'b0;
    mem_readdatavalid  = 1'b0;

    // Reset state
    cyc();
    cyc();
    settle();
    chk("rst_i_wait", 32'(ibus_waitrequest), 32'd1);
    chk("rst_d_wait", 32'(dbus_waitrequest), 32'd1);
    chk("rst_i_rdv", 32'(ibus_readdatavalid), 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_be", 32'(mem_byteenable), 32'd0);
    chk("rst_i_data", ibus_agent_to_host, 32'd0);
    chk("rst_d_data", dbus_agent_to_host, 32'd0);
    reset = 1'b0;

    // 1: lone fetch read, 3-cycle transaction
    cyc();
    ibus_read    = 1'b1;
    ibus_address = 32'h100;
    settle();
    chk("t1_idle_wait", 32'(ibus_waitrequest), 32'd1);
    chk("t1_idle_mrd", 32'(mem_read), 32'd0);
    cyc();
    settle();
    chk("t1_cmd_mrd", 32'(mem_read), 32'd1);
    chk("t1_cmd_addr", mem_address, 32'h100);
    chk("t1_cmd_be", 32'(mem_byteenable), 32'hF);
    chk("t1_cmd_iwait", 32'(ibus_waitrequest), 32'd0);
    chk("t1_cmd_dwait", 32'(dbus_waitrequest), 32'd1);
    cyc();
    ibus_read         = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_agent_to_host = 32'h1234_5678;
    settle();
    chk("t1_resp_mrd", 32'(mem_read), 32'd0);
    chk("t1_resp_irdv", 32'(ibus_readdatavalid), 32'd1);
    chk("t1_resp_idata", ibus_agent_to_host, 32'h1234_5678);
    chk("t1_resp_drdv", 32'(dbus_readdatavalid), 32'd0);
    chk("t1_resp_ddata", dbus_agent_to_host, 32'd0);
    cyc();
    mem_readdatavalid = 1'b0;
    mem_agent_to_host = 32'hAAAA_AAAA;
    settle();
    chk("t1_after_irdv", 32'(ibus_readdatavalid), 32'd0);
    chk("t1_hold_idata", ibus_agent_to_host, 32'h1234_5678);

    // 2: data write and fetch collide, data first
    dbus_write         = 1'b1;
    dbus_address       = 32'h200;
    dbus_byteenable    = 4'b0011;
    dbus_host_to_agent = 32'hDEAD_BEEF;
    ibus_read          = 1'b1;
    ibus_address       = 32'h104;
    cyc();
    settle();
    chk("t2_d_mwr", 32'(mem_write), 32'd1);
    chk("t2_d_mrd", 32'(mem_read), 32'd0);
    chk("t2_d_addr", mem_address, 32'h200);
    chk("t2_d_be", 32'(mem_byteenable), 32'h3);
    chk("t2_d_wdata", mem_host_to_agent, 32'hDEAD_BEEF);
    chk("t2_d_iwait", 32'(ibus_waitrequest), 32'd1);
    cyc();
    dbus_write = 1'b0;
    settle();
    chk("t2_idle_mwr", 32'(mem_write), 32'd0);
    cyc();
    settle();
    chk("t2_i_mrd", 32'(mem_read), 32'd1);
    chk("t2_i_addr", mem_address, 32'h104);
    cyc();
    ibus_read         = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_agent_to_host = 32'h0BAD_F00D;
    settle();
    chk("t2_i_rdata", ibus_agent_to_host, 32'h0BAD_F00D);
    cyc();
    mem_readdatavalid = 1'b0;

    // 3: starvation limit, four data grants then fetch
    dbus_write         = 1'b1;
    dbus_address       = 32'h300;
    dbus_byteenable    = 4'hF;
    dbus_host_to_agent = 32'h3333_3333;
    ibus_read          = 1'b1;
    ibus_address       = 32'h108;
    for (int k = 0; k < 4; k++) begin
      cyc();
      settle();
      chk($sformatf("t3_d_grant%0d", k), 32'(mem_write), 32'd1);
      cyc();
    end
    cyc();
    settle();
    chk("t3_i_grant_rd", 32'(mem_read), 32'd1);
    chk("t3_i_grant_wr", 32'(mem_write), 32'd0);
    chk("t3_i_addr", mem_address, 32'h108);
    chk("t3_dwait", 32'(dbus_waitrequest), 32'd1);
    cyc();
    ibus_read         = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_agent_to_host = 32'h1111_2222;
    settle();
    chk("t3_i_rdv", 32'(ibus_readdatavalid), 32'd1);
    cyc();
    mem_readdatavalid = 1'b0;
    ibus_read         = 1'b1;
    cyc();
    settle();
    chk("t3_streak_clr", 32'(mem_write), 32'd1);
    cyc();
    ibus_read  = 1'b0;
    dbus_write = 1'b0;
    cyc();
    settle();
    chk("t3_quiet", {30'd0, mem_read, mem_write}, 32'd0);

    // 4: memory wait states on a data read
    dbus_read       = 1'b1;
    dbus_address    = 32'h400;
    dbus_byteenable = 4'b1100;
    mem_waitrequest = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("t4_dwait%0d", k), 32'(dbus_waitrequest), 32'd1);
      chk($sformatf("t4_mrd%0d", k), 32'(mem_read), 32'd1);
      chk($sformatf("t4_addr%0d", k), mem_address, 32'h400);
      chk($sformatf("t4_be%0d", k), 32'(mem_byteenable), 32'hC);
      cyc();
    end
    mem_waitrequest = 1'b0;
    settle();
    chk("t4_accept", 32'(dbus_waitrequest), 32'd0);
    cyc();
    dbus_read         = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_agent_to_host = 32'hCAFE_F00D;
    settle();
    chk("t4_single_acc", 32'(mem_read), 32'd0);
    chk("t4_drdv", 32'(dbus_readdatavalid), 32'd1);
    chk("t4_ddata", dbus_agent_to_host, 32'hCAFE_F00D);
    chk("t4_irdv", 32'(ibus_readdatavalid), 32'd0);
    chk("t4_ihold", ibus_agent_to_host, 32'h1111_2222);
    cyc();
    mem_readdatavalid = 1'b0;

    // 5: reset during response
    ibus_read    = 1'b1;
    ibus_address = 32'h500;
    cyc();
    cyc();
    ibus_read = 1'b0;
    reset     = 1'b1;
    cyc();
    reset             = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_agent_to_host = 32'h5555_5555;
    settle();
    chk("t5_irdv", 32'(ibus_readdatavalid), 32'd0);
    chk("t5_drdv", 32'(dbus_readdatavalid), 32'd0);
    chk("t5_idata", ibus_agent_to_host, 32'd0);
    chk("t5_ddata", dbus_agent_to_host, 32'd0);
    chk("t5_iwait", 32'(ibus_waitrequest), 32'd1);
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    chk("t5_idle", {30'd0, mem_read, mem_write}, 32'd0);

    // 6: illegal read+write from data host behaves as a write
    dbus_read          = 1'b1;
    dbus_write         = 1'b1;
    dbus_address       = 32'h600;
    dbus_byteenable    = 4'hF;
    dbus_host_to_agent = 32'h6666_6666;
    cyc();
    settle();
    chk("t6_protocol_violation", 32'(dbus_read & dbus_write & ~dbus_waitrequest), 32'd1);
    chk("t6_mwr", 32'(mem_write), 32'd1);
    chk("t6_mrd", 32'(mem_read), 32'd0);
    chk("t6_wdata", mem_host_to_agent, 32'h6666_6666);
    cyc();
    settle();
    chk("t6_back_idle", 32'(dbus_waitrequest), 32'd1);
    chk("t6_no_write", 32'(mem_write), 32'd0);
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
